// File: rtl/nonce_hash_sequencer.sv
// nonce_hash_sequencer: walks a nonce range and, for each nonce, runs the two
// SHA-256 passes of a bitcoin double hash on an attached simplified_sha256
// core. Pass 1 compresses the padded second header block on top of the
// midstate. Pass 2 compresses the padded 256-bit digest from the standard IV.
// Each final digest is offered on a valid/ready result port together with its
// nonce.
module nonce_hash_sequencer #(
  parameter int unsigned CORE_LAT = 67
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] midstate [8],
  input  logic [31:0] tail [3],
  input  logic [31:0] nonce_base,
  input  logic [31:0] nonce_count,
  output logic        core_start,
  output logic [31:0] core_message [16],
  output logic [31:0] core_g [8],
  input  logic        core_done,
  input  logic [31:0] core_h [8],
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_nonce,
  output logic [31:0] result_hash [8],
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] PadWord = 32'h8000_0000;
  localparam logic [31:0] P1Len   = 32'h0000_0280;  // 640-bit header
  localparam logic [31:0] P2Len   = 32'h0000_0100;  // 256-bit digest
  localparam logic [31:0] Iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // The core needs at least one cycle between its start and its done pulse.
  if (CORE_LAT == 0) begin : gen_lat_check
    $error("CORE_LAT must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StP1Start,
    StP1Wait,
    StP2Start,
    StP2Wait,
    StOut,
    StFin
  } state_e;

  state_e      state_q;
  logic [31:0] mid_q [8];
  logic [31:0] tail_q [3];
  logic [31:0] nonce_q;
  logic [31:0] remaining_q;
  logic [31:0] hmid_q [8];
  // msg_en_q keeps the core-facing buses at zero until the first job loads them.
  logic        msg_en_q;
  // pass2_q selects which block the core sees; it flips only on the edge that
  // raises core_start, so the buses stay put for the whole pass.
  logic        pass2_q;

  // Core message and initial digest, built from registered job state only.
  always_comb begin
    for (int i = 0; i < 16; i++) core_message[i] = '0;
    for (int i = 0; i < 8; i++) core_g[i] = '0;
    if (msg_en_q) begin
      if (pass2_q) begin
        for (int i = 0; i < 8; i++) core_message[i] = hmid_q[i];
        core_message[8]  = PadWord;
        core_message[15] = P2Len;
        for (int i = 0; i < 8; i++) core_g[i] = Iv[i];
      end else begin
        for (int i = 0; i < 3; i++) core_message[i] = tail_q[i];
        core_message[3]  = nonce_q;
        core_message[4]  = PadWord;
        core_message[15] = P1Len;
        for (int i = 0; i < 8; i++) core_g[i] = mid_q[i];
      end
    end
  end

  // Sequencer FSM with registered control and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      core_start   <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_nonce <= '0;
      nonce_q      <= '0;
      remaining_q  <= '0;
      msg_en_q     <= 1'b0;
      pass2_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        result_hash[i] <= '0;
        hmid_q[i]      <= '0;
        mid_q[i]       <= '0;
      end
      for (int i = 0; i < 3; i++) tail_q[i] <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < 8; i++) mid_q[i] <= midstate[i];
            for (int i = 0; i < 3; i++) tail_q[i] <= tail[i];
            nonce_q     <= nonce_base;
            remaining_q <= nonce_count;
            busy        <= 1'b1;
            if (nonce_count == '0) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q    <= StP1Start;
              core_start <= 1'b1;
              msg_en_q   <= 1'b1;
              pass2_q    <= 1'b0;
            end
          end
        end
        StP1Start: state_q <= StP1Wait;
        StP1Wait: begin
          if (core_done) begin
            for (int i = 0; i < 8; i++) hmid_q[i] <= core_h[i];
            pass2_q    <= 1'b1;
            core_start <= 1'b1;
            state_q    <= StP2Start;
          end
        end
        StP2Start: state_q <= StP2Wait;
        StP2Wait: begin
          if (core_done) begin
            for (int i = 0; i < 8; i++) result_hash[i] <= core_h[i];
            result_nonce <= nonce_q;
            result_valid <= 1'b1;
            state_q      <= StOut;
          end
        end
        StOut: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            remaining_q  <= remaining_q - 32'd1;
            nonce_q      <= nonce_q + 32'd1;
            if (remaining_q == 32'd1) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q    <= StP1Start;
              core_start <= 1'b1;
              pass2_q    <= 1'b0;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_hash_sequencer.sv
// Bench for nonce_hash_sequencer: a behavioural SHA-256 core with fixed
// latency, directed jobs, and a reference double-SHA model.
module tb_nonce_hash_sequencer;

  localparam int unsigned CORE_LAT = 67;

  typedef logic [31:0] w3_t [3];
  typedef logic [31:0] w8_t [8];
  typedef logic [31:0] w16_t [16];

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam w8_t IV = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  w8_t         midstate;
  w3_t         tail;
  logic [31:0] nonce_base;
  logic [31:0] nonce_count;
  logic        core_start;
  w16_t        core_message;
  w8_t         core_g;
  logic        core_done;
  w8_t         core_h;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_nonce;
  w8_t         result_hash;
  logic        busy;
  logic        done;

  nonce_hash_sequencer #(.CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .midstate(midstate), .tail(tail),
    .nonce_base(nonce_base), .nonce_count(nonce_count), .core_start(core_start),
    .core_message(core_message), .core_g(core_g), .core_done(core_done), .core_h(core_h),
    .result_valid(result_valid), .result_ready(result_ready), .result_nonce(result_nonce),
    .result_hash(result_hash), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic w8_t compress(input w8_t hin, input w16_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    w8_t         r;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
    r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
    return r;
  endfunction

  function automatic w16_t p1_block(input w3_t t, input logic [31:0] n);
    w16_t b;
    for (int i = 0; i < 16; i++) b[i] = '0;
    for (int i = 0; i < 3; i++) b[i] = t[i];
    b[3] = n; b[4] = 32'h80000000; b[15] = 32'h00000280;
    return b;
  endfunction

  function automatic w16_t p2_block(input w8_t hm);
    w16_t b;
    for (int i = 0; i < 16; i++) b[i] = '0;
    for (int i = 0; i < 8; i++) b[i] = hm[i];
    b[8] = 32'h80000000; b[15] = 32'h00000100;
    return b;
  endfunction

  function automatic w8_t dsha(input w8_t m, input w3_t t, input logic [31:0] n);
    return compress(IV, p2_block(compress(m, p1_block(t, n))));
  endfunction

  // ---------------- behavioural core ----------------
  w16_t cm_msg;
  w8_t  cm_g;
  int   cm_cnt;
  int   core_unstable = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cm_cnt <= 0;
      for (int i = 0; i < 8; i++) core_h[i] <= '0;
    end else begin
      if (core_start) begin
        cm_msg <= core_message;
        cm_g   <= core_g;
        cm_cnt <= CORE_LAT;
      end else if (cm_cnt > 0) begin
        cm_cnt <= cm_cnt - 1;
      end
      if (cm_cnt == 2) core_h <= compress(core_g, core_message);
      if (cm_cnt == 1 && (core_message != cm_msg || core_g != cm_g))
        core_unstable <= core_unstable + 1;
    end
  end
  assign core_done = (cm_cnt == 1);

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          done_cnt = 0;
  logic        rv_prev = 1'b0;
  int          start_cyc_q [$];
  int          rv_cyc_q [$];
  w16_t        snap_msg_q [$];
  w8_t         snap_g_q [$];
  logic [31:0] hs_nonce_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start) begin
      start_cyc_q.push_back(cyc);
      snap_msg_q.push_back(core_message);
      snap_g_q.push_back(core_g);
    end
    if (result_valid && !rv_prev) rv_cyc_q.push_back(cyc);
    rv_prev <= result_valid;
    if (result_valid && result_ready) hs_nonce_q.push_back(result_nonce);
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] acc;
    check({name, " core_start"}, {31'b0, core_start}, 32'd0);
    check({name, " result_valid"}, {31'b0, result_valid}, 32'd0);
    check({name, " busy"}, {31'b0, busy}, 32'd0);
    check({name, " done"}, {31'b0, done}, 32'd0);
    check({name, " result_nonce"}, result_nonce, 32'd0);
    acc = '0;
    for (int i = 0; i < 8; i++) acc |= result_hash[i];
    check({name, " result_hash"}, acc, 32'd0);
    acc = '0;
    for (int i = 0; i < 16; i++) acc |= core_message[i];
    check({name, " core_message"}, acc, 32'd0);
    acc = '0;
    for (int i = 0; i < 8; i++) acc |= core_g[i];
    check({name, " core_g"}, acc, 32'd0);
  endtask

  task automatic start_job(input w8_t m, input w3_t t, input logic [31:0] base,
                           input logic [31:0] cnt);
    @(negedge clk);
    midstate = m; tail = t; nonce_base = base; nonce_count = cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for a result, holds ready low for 'stall' cycles while checking it, then accepts.
  task automatic collect(input string name, input w8_t m, input w3_t t,
                         input logic [31:0] n, input int stall);
    int  waited;
    int  nstarts;
    w8_t exp;
    exp = dsha(m, t, n);
    waited = 0;
    while (!result_valid && waited < 2 * CORE_LAT + 40) begin
      @(negedge clk);
      waited++;
    end
    if (!result_valid) begin
      check({name, " result_valid timeout"}, 32'd0, 32'd1);
      return;
    end
    nstarts = start_cyc_q.size();
    for (int s = 0; s <= stall; s++) begin
      check({name, " valid"}, {31'b0, result_valid}, 32'd1);
      check({name, " nonce"}, result_nonce, n);
      for (int i = 0; i < 8; i++)
        check($sformatf("%s hash[%0d]", name, i), result_hash[i], exp[i]);
      if (s < stall) @(negedge clk);
    end
    if (stall > 0)
      check({name, " no core_start while stalled"}, start_cyc_q.size(), nstarts);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  typedef struct {
    int          pass;
    int          sel;   // 0 = message word, 1 = initial digest word
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [$];

  function automatic void add_vec(input int pass, input int sel, input int idx,
                                  input logic [31:0] exp);
    vec_t v;
    v.pass = pass; v.sel = sel; v.idx = idx; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    w3_t  t1, t2, t3, t4, t5, gt;
    w16_t hdr;
    w8_t  gmid, h1;
    int   idx, rvi, hsi, dc, w;

    t1 = '{32'h11111111, 32'h22222222, 32'h33333333};
    t2 = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678};
    t3 = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    t4 = '{32'hCAFEF00D, 32'hFEEDFACE, 32'h00C0FFEE};
    t5 = '{32'h13579BDF, 32'h2468ACE0, 32'h0BADF00D};
    gt = '{32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
    hdr = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
            32'h888a5132, 32'h3a9fb8aa};
    gmid = compress(IV, hdr);

    // Hand-written expectations for the first job's two core launches.
    add_vec(0, 0, 0, 32'h11111111);
    add_vec(0, 0, 1, 32'h22222222);
    add_vec(0, 0, 2, 32'h33333333);
    add_vec(0, 0, 3, 32'hDEADBEEF);
    add_vec(0, 0, 4, 32'h80000000);
    for (int i = 5; i < 15; i++) add_vec(0, 0, i, 32'h0);
    add_vec(0, 0, 15, 32'h00000280);
    for (int i = 0; i < 8; i++) add_vec(0, 1, i, IV[i]);
    add_vec(1, 0, 8, 32'h80000000);
    for (int i = 9; i < 15; i++) add_vec(1, 0, i, 32'h0);
    add_vec(1, 0, 15, 32'h00000100);
    add_vec(1, 1, 0, 32'h6a09e667);
    add_vec(1, 1, 7, 32'h5be0cd19);

    midstate = IV; tail = t1; nonce_base = '0; nonce_count = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single nonce from the IV midstate.
    idx = start_cyc_q.size(); rvi = rv_cyc_q.size(); dc = done_cnt;
    start_job(IV, t1, 32'hDEADBEEF, 32'd1);
    check("t1 busy", {31'b0, busy}, 32'd1);
    collect("t1", IV, t1, 32'hDEADBEEF, 0);
    check("t1 done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("t1 done drop", {31'b0, done}, 32'd0);
    check("t1 busy drop", {31'b0, busy}, 32'd0);
    check("t1 done count", done_cnt - dc, 32'd1);
    check("t1 core_start count", start_cyc_q.size() - idx, 32'd2);
    if (start_cyc_q.size() >= idx + 2 && rv_cyc_q.size() > rvi) begin
      check("t1 p2 start offset", start_cyc_q[idx+1] - start_cyc_q[idx], CORE_LAT + 1);
      check("t1 valid offset", rv_cyc_q[rvi] - start_cyc_q[idx], 2 * CORE_LAT + 2);
      foreach (vecs[v]) begin
        if (vecs[v].sel == 0)
          check($sformatf("vec p%0d w%0d", vecs[v].pass + 1, vecs[v].idx),
                snap_msg_q[idx + vecs[v].pass][vecs[v].idx], vecs[v].exp);
        else
          check($sformatf("vec p%0d g%0d", vecs[v].pass + 1, vecs[v].idx),
                snap_g_q[idx + vecs[v].pass][vecs[v].idx], vecs[v].exp);
      end
      h1 = compress(IV, p1_block(t1, 32'hDEADBEEF));
      for (int i = 0; i < 8; i++)
        check($sformatf("t1 p2 w%0d", i), snap_msg_q[idx+1][i], h1[i]);
    end

    // Genesis block header.
    start_job(gmid, gt, 32'h1DAC2B7C, 32'd1);
    collect("genesis", gmid, gt, 32'h1DAC2B7C, 0);
    @(negedge clk);
    check("genesis hash[7] after done", result_hash[7], 32'h00000000);
    check("genesis hash[6] after done", result_hash[6], 32'h68D61900);

    // Nonce wrap with five-cycle ready stalls.
    hsi = hs_nonce_q.size(); dc = done_cnt;
    start_job(IV, t2, 32'hFFFFFFFE, 32'd3);
    collect("range0", IV, t2, 32'hFFFFFFFE, 5);
    collect("range1", IV, t2, 32'hFFFFFFFF, 5);
    collect("range2", IV, t2, 32'h00000000, 5);
    check("range done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("range done count", done_cnt - dc, 32'd1);
    check("range handshakes", hs_nonce_q.size() - hsi, 32'd3);

    // Back-to-back results with ready held high.
    rvi = rv_cyc_q.size(); hsi = hs_nonce_q.size();
    result_ready = 1'b1;
    start_job(IV, t3, 32'h00000005, 32'd2);
    w = 0;
    while (!done && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("spacing done seen", {31'b0, done}, 32'd1);
    result_ready = 1'b0;
    @(negedge clk);
    if (rv_cyc_q.size() >= rvi + 2 && hs_nonce_q.size() >= hsi + 2) begin
      check("spacing cycles", rv_cyc_q[rvi+1] - rv_cyc_q[rvi], 2 * CORE_LAT + 3);
      check("spacing nonce0", hs_nonce_q[hsi], 32'h00000005);
      check("spacing nonce1", hs_nonce_q[hsi+1], 32'h00000006);
    end else begin
      check("spacing result count", hs_nonce_q.size() - hsi, 32'd2);
    end
    h1 = dsha(IV, t3, 32'h00000006);
    check("spacing last hash[0] held", result_hash[0], h1[0]);

    // Zero count: one done pulse, no core activity.
    idx = start_cyc_q.size(); dc = done_cnt;
    start_job(gmid, gt, 32'h00000077, 32'd0);
    check("zero done", {31'b0, done}, 32'd1);
    check("zero busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("zero done drop", {31'b0, done}, 32'd0);
    check("zero busy drop", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero core_start", start_cyc_q.size(), idx);
    check("zero done count", done_cnt - dc, 32'd1);

    // Start pulse with new inputs while a job is running.
    idx = start_cyc_q.size();
    start_job(IV, t4, 32'h00000100, 32'd1);
    repeat (20) @(negedge clk);
    midstate = gmid; tail = gt; nonce_base = 32'h00000999; nonce_count = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("busy start", IV, t4, 32'h00000100, 0);
    check("busy start done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("busy start idle", {31'b0, busy}, 32'd0);
    check("busy start launches", start_cyc_q.size() - idx, 32'd2);

    // Reset during the second pass.
    idx = start_cyc_q.size();
    start_job(IV, t5, 32'h00000042, 32'd1);
    w = 0;
    while (start_cyc_q.size() < idx + 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reset mid p2 reached", start_cyc_q.size() - idx, 32'd2);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    @(negedge clk);
    check_all_zero("mid reset held");
    reset_n = 1'b1;
    repeat (CORE_LAT + 5) @(negedge clk);
    check("post reset idle", {31'b0, busy}, 32'd0);
    check("post reset no valid", {31'b0, result_valid}, 32'd0);
    check("post reset launches", start_cyc_q.size() - idx, 32'd2);
    start_job(IV, t5, 32'h00000043, 32'd1);
    collect("post reset", IV, t5, 32'h00000043, 0);
    check("post reset done", {31'b0, done}, 32'd1);
    @(negedge clk);

    check("core inputs stable per pass", core_unstable, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nonce_hash_sequencer.md
# nonce_hash_sequencer

Drives one `simplified_sha256` core (NUM_OF_WORDS = 16) through the double-SHA-256 of a bitcoin header for a range of nonces. For each nonce it:
- builds the padded second header block from the precomputed midstate and the three header-tail words;
- hashes it, then builds and hashes the padded 256-bit digest block;
- presents the final 8-word hash and its nonce on a valid/ready result port.

It sits between the mining top level and the hash core.

## Interface
Parameters
- CORE_LAT, 67, cycles from the `core_start` cycle to the `core_done` cycle of the attached core; used only by the bench.

Ports
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start; sampled only in IDLE
- midstate[8]  in  32 each  H after header block 1; the pass-1 initial digest
- tail[3]  in  32 each  header words 16..18 (merkle tail, time, bits)
- nonce_base  in  32  first nonce
- nonce_count  in  32  number of nonces to try
- core_start  out  1  one-cycle start to the core
- core_message[16]  out  32 each  message words to the core
- core_g[8]  out  32 each  initial digest to the core
- core_done  in  1  core done pulse
- core_h[8]  in  32 each  core output digest; valid from the `core_done` cycle
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_nonce  out  32  nonce of the current result
- result_hash[8]  out  32 each  final double-SHA digest, H0..H7
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes

## Operation
- States: IDLE, P1_START, P1_WAIT, P2_START, P2_WAIT, OUT, FIN.
- IDLE, start=1:
  - latch midstate, tail, nonce_base into nonce, nonce_count into remaining;
  - if nonce_count = 0, go FIN; else go P1_START.
- P1 message:
  - w0..w2 = tail;
  - w3 = nonce;
  - w4 = 0x80000000;
  - w5..w14 = 0;
  - w15 = 0x00000280.
  - core_g = latched midstate.
- P1_START: core_start=1 for this cycle only; next state P1_WAIT.
- P1_WAIT: on core_done, register core_h into hmid[8]; next state P2_START.
- P2 message:
  - w0..w7 = hmid;
  - w8 = 0x80000000;
  - w9..w14 = 0;
  - w15 = 0x00000100.
  - core_g = standard IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- P2_START: core_start=1 for one cycle; next state P2_WAIT.
- P2_WAIT: on core_done, register core_h into result_hash and nonce into result_nonce; next state OUT.
- OUT: result_valid=1 until result_valid & result_ready. On that handshake:
  - remaining decrements;
  - nonce increments, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000);
  - if remaining was 1, go FIN; else go P1_START.
- FIN: done=1 for one cycle; next state IDLE.
- core_message and core_g are selected by the pass (P1_* vs P2_*). They hold stable from the start cycle through core_done, because the core reads message words over many cycles.
- start outside IDLE is ignored; latched inputs do not change mid-job.
- result_hash and result_nonce hold their values until the next P2 capture. They remain readable after done.

## Timing
- Reset: state = IDLE; all outputs 0 (core_start, result_valid, busy, done, result_nonce, result_hash, core_message, core_g); hmid = 0; nonce = 0; remaining = 0.
- Reset mid-job aborts immediately. The core shares reset_n, so no stale core_done can follow.
- Cycle t = first P1_START cycle:
  - core_start at t;
  - core_done at t+CORE_LAT;
  - second core_start at t+CORE_LAT+1 (core is back in IDLE);
  - core_done at t+2·CORE_LAT+1;
  - result_valid from t+2·CORE_LAT+2.
- With result_ready held high, successive results are 2·CORE_LAT+3 cycles apart (137 for CORE_LAT = 67).
- Stall: result_valid stays high and result_* stay stable while result_ready = 0; the next nonce does not start.
- done is asserted in the cycle after the last handshake; busy drops in the same cycle done drops.
- nonce_count = 0: start → FIN → IDLE, with exactly one done pulse 1 cycle after start and no core_start.

## Test plan
- Single nonce, midstate = IV, tail = {0x11111111, 0x22222222, 0x33333333}, base = 0xDEADBEEF:
  - at the P1 core_start: core_message = {11111111, 22222222, 33333333, DEADBEEF, 80000000, 0×10, 00000280} and core_g = midstate;
  - at the P2 core_start: core_message w8 = 80000000, w15 = 00000100, core_g0 = 6a09e667;
  - result_hash matches the software double-SHA model;
  - done pulses once.
- Genesis header, using its midstate and tail, base = 0x1DAC2B7C, count = 1:
  - result_hash[7] = 0x00000000;
  - result_hash[6] = 0x68D61900.
- Range with ready stalls: base = 0xFFFFFFFE, count = 3, result_ready low for 5 cycles on each result:
  - result_nonce sequence is FFFFFFFE, FFFFFFFF, 00000000;
  - outputs stay stable during stalls;
  - with ready high the spacing is exactly 137 cycles.
- Zero count and busy start: nonce_count = 0 gives a done pulse 1 cycle after start with no core_start; a start pulse mid-job changes no latched value.
- Reset mid-job: assert reset_n low during P2_WAIT:
  - all outputs read 0 while reset is asserted;
  - a subsequent job with count = 1 produces the correct hash.
